// File: rtl/alarm_ctrl.sv
// alarm_ctrl: multi-channel alarm with per-channel ring timer and registered-state outputs
// Define ALARM_SNOOZE_EN to compile in the SNOOZED state, snooze input and snoozed flags.
module alarm_ctrl #(
  parameter int NUM_ALARMS   = 2,
  parameter int RING_MINUTES = 1,
  parameter int SNOOZE_MIN   = 9
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            tick_min,
  input  logic [6:0]                                      tmin,
  input  logic [6:0]                                      thrs,
  input  logic [7*NUM_ALARMS-1:0]                         amin,
  input  logic [7*NUM_ALARMS-1:0]                         ahrs,
  input  logic [NUM_ALARMS-1:0]                           arm,
  input  logic                                            snooze,
  input  logic                                            stop,
  output logic                                            buzz,
  output logic [(NUM_ALARMS>1?$clog2(NUM_ALARMS):1)-1:0]  ring_id,
  output logic [NUM_ALARMS-1:0]                           snoozed
);
`ifdef ALARM_SNOOZE_EN
  localparam int CMAX = RING_MINUTES > SNOOZE_MIN ? RING_MINUTES : SNOOZE_MIN;
`else
  localparam int CMAX = RING_MINUTES;
`endif
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1;
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;
  logic snz;
  logic [NUM_ALARMS-1:0] ringing;
`ifdef ALARM_SNOOZE_EN
  assign snz = snooze;
`else
  logic unused_snooze;
  assign snz = 1'b0;
  assign unused_snooze = snooze;
`endif
  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    state_t st;
    logic [CW-1:0] cnt;
    logic match;
    assign match = tick_min && tmin == amin[7*i+:7] && thrs == ahrs[7*i+:7];
    always_ff @(posedge clk) begin
      if (!rst_n || stop || !arm[i]) begin
        st  <= IDLE;
        cnt <= '0;
      end else begin
        case (st)
          IDLE: if (match) begin
            st  <= RINGING;
            cnt <= CW'(RING_MINUTES);
          end
          RINGING: if (snz) begin
            st  <= SNOOZED;
            cnt <= CW'(SNOOZE_MIN);
          end else if (tick_min) begin
            st  <= cnt == CW'(1) ? IDLE : RINGING;
            cnt <= cnt - 1'b1;
          end
          SNOOZED: if (tick_min) begin
            st  <= cnt == CW'(1) ? RINGING : SNOOZED;
            cnt <= cnt == CW'(1) ? CW'(RING_MINUTES) : cnt - 1'b1;
          end
          default: st <= IDLE;
        endcase
      end
    end
    assign ringing[i] = st == RINGING;
`ifdef ALARM_SNOOZE_EN
    assign snoozed[i] = st == SNOOZED;
`else
    assign snoozed[i] = 1'b0;
`endif
  end
  assign buzz = |ringing;
  // scan downward so the lowest ringing index is the last write
  always_comb begin
    ring_id = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--)
      if (ringing[k]) ring_id = IW'(k);
  end
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed checks of alarm_ctrl with NUM_ALARMS=2, RING_MINUTES=3, SNOOZE_MIN=9
module tb_alarm_ctrl;
  logic        clk = 0, rst_n = 0, tick_min = 0, snooze = 0, stop = 0;
  logic [6:0]  tmin = 0, thrs = 0;
  logic [13:0] amin = 0, ahrs = 0;
  logic [1:0]  arm = 0;
  logic        buzz;
  logic [0:0]  ring_id;
  logic [1:0]  snoozed;
  int checks = 0, failures = 0;

  alarm_ctrl #(.NUM_ALARMS(2), .RING_MINUTES(3), .SNOOZE_MIN(9)) dut (
    .clk(clk), .rst_n(rst_n), .tick_min(tick_min), .tmin(tmin), .thrs(thrs),
    .amin(amin), .ahrs(ahrs), .arm(arm), .snooze(snooze), .stop(stop),
    .buzz(buzz), .ring_id(ring_id), .snoozed(snoozed)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      tick_min = 1;
      cyc();
      tick_min = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int b, input int id, input int s);
    chk({tag, ".buzz"}, 32'(buzz), b);
    chk({tag, ".ring_id"}, 32'(ring_id), id);
    chk({tag, ".snoozed"}, 32'(snoozed), s);
  endtask

  initial begin
    arm = 2'b11; amin = {7'd0, 7'd30}; ahrs = {7'd0, 7'd7}; tmin = 30; thrs = 7;
    tick_min = 1;
    cyc(2);
    tick_min = 0;
    chk3("reset", 0, 0, 0);
    rst_n = 1;
    cyc(3); chk3("match_no_tick", 0, 0, 0);
    arm = 2'b01;
    thrs = 8; tick(); chk3("hour_mismatch", 0, 0, 0);
    thrs = 7; arm = 2'b00; tick(); chk3("disarmed_match", 0, 0, 0);
    arm = 2'b01; tick(); chk3("fire_0730", 1, 0, 0);
    tick(); chk3("match_while_ringing", 1, 0, 0);
    tmin = 31; tick(); chk3("ring_t2", 1, 0, 0);
    tmin = 32; tick(); chk3("ring_end_no_reload", 0, 0, 0);
    amin[6:0] = 0; ahrs[6:0] = 6; tmin = 0; thrs = 6;
    tick(); chk3("fire_0600", 1, 0, 0);
    cyc(100); chk3("hold_no_tick", 1, 0, 0);
    tmin = 1; tick(); tmin = 2; tick(); chk3("ring_0602", 1, 0, 0);
    tmin = 3; tick(); chk3("off_0603", 0, 0, 0);
    tmin = 0; cyc(100); chk3("no_retrigger", 0, 0, 0);
    tick(); chk3("refire", 1, 0, 0);
    stop = 1; cyc(); stop = 0; chk3("stop", 0, 0, 0);
    stop = 1; tick(); stop = 0; chk3("stop_vs_match", 0, 0, 0);
`ifndef ALARM_SNOOZE_EN
    tick(); chk3("fire_pre_snooze", 1, 0, 0);
    snooze = 1; cyc(); snooze = 0; chk3("snooze_ignored", 1, 0, 0);
    stop = 1; cyc(); stop = 0; chk3("stop2", 0, 0, 0);
`else
    tick(); chk3("fire_pre_snooze", 1, 0, 0);
    tmin = 5;
    snooze = 1; cyc(); snooze = 0; chk3("snoozed", 0, 0, 1);
    tick(8); chk3("snooze_8_ticks", 0, 0, 1);
    tick(); chk3("rering", 1, 0, 0);
    snooze = 1; tick(); snooze = 0; chk3("snooze_with_tick", 0, 0, 1);
    tick(8); chk3("snooze_tick_8", 0, 0, 1);
    tick(); chk3("rering2", 1, 0, 0);
    snooze = 1; stop = 1; cyc(); snooze = 0; stop = 0; chk3("stop_vs_snooze", 0, 0, 0);
    tmin = 0; tick(); chk3("fire_pre_disarm", 1, 0, 0);
    tmin = 5; snooze = 1; cyc(); snooze = 0; chk3("snoozed2", 0, 0, 1);
    arm = 2'b00; cyc(); chk3("disarm_snoozed", 0, 0, 0);
    arm = 2'b01; tick(9); chk3("no_rering", 0, 0, 0);
`endif
    amin = {7'd0, 7'd0}; ahrs = {7'd12, 7'd12}; tmin = 0; thrs = 12; arm = 2'b11;
    tick(); chk3("both_fire", 1, 0, 0);
    arm = 2'b10; cyc(); chk3("ch1_only", 1, 1, 0);
    arm = 2'b00; cyc(); chk3("all_disarmed", 0, 0, 0);
    arm = 2'b11; tick(); chk3("both_fire2", 1, 0, 0);
    rst_n = 0; cyc(); rst_n = 1; chk3("reset_mid_ring", 0, 0, 0);
    tick(); chk3("fire_after_reset", 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Multi-channel alarm controller for the digital clock. It compares the current time against `NUM_ALARMS` independently armed alarm settings at each minute boundary and drives a registered `buzz` output. Each channel runs its own ring timer, so an alarm auto-silences after `RING_MINUTES`. Compiled-in snooze support is optional. It sits beside the timekeeping counters, which supply the time and the minute-tick strobe.

## Interface
- `NUM_ALARMS`, 2: number of alarm channels, 1..8
- `RING_MINUTES`, 1: minutes a channel buzzes before auto-off, 1..127
- `SNOOZE_MIN`, 9: snooze delay in minutes, 1..127

Ports:
- `clk` in 1: the block's only clock
- `rst_n` in 1: reset; synchronous, active-low
- `tick_min` in 1: one-cycle strobe, high in the cycle after the time counters advance to a new minute
- `tmin` in 7: current minutes, 0..59
- `thrs` in 7: current hours, 0..23
- `amin` in 7*NUM_ALARMS: alarm minutes; channel i occupies bits [7i+6:7i]
- `ahrs` in 7*NUM_ALARMS: alarm hours, packed the same way
- `arm` in NUM_ALARMS: per-channel enable, level
- `snooze` in 1: one-cycle request
- `stop` in 1: one-cycle request
- `buzz` out 1: high while any channel is RINGING
- `ring_id` out $clog2(NUM_ALARMS) (min 1): index of the lowest RINGING channel; 0 when none
- `snoozed` out NUM_ALARMS: per-channel SNOOZED flag

## Operation
- Per-channel FSM with states IDLE, RINGING and SNOOZED. Each channel has a down-counter `cnt`, sized $clog2(max(RING_MINUTES,SNOOZE_MIN)+1).
- Priority, highest first: reset, then `stop`, then `!arm[i]`, then `snooze`, then `tick_min`.
- IDLE → RINGING when `tick_min && arm[i] && tmin==amin[i] && thrs==ahrs[i]`. Load `cnt=RING_MINUTES`.
  - The match is evaluated only on `tick_min`. Equality at other cycles is ignored, so an alarm fires once per minute boundary, not continuously.
- RINGING:
  - On `tick_min`: if `cnt==1`, go to IDLE; otherwise decrement `cnt`.
  - On `snooze`: go to SNOOZED and load `cnt=SNOOZE_MIN`.
- SNOOZED, on `tick_min`: if `cnt==1`, go to RINGING and load `cnt=RING_MINUTES`; otherwise decrement `cnt`.
- `stop` sends every channel to IDLE, whatever its state.
- `arm[i]` low forces channel i to IDLE in the same clock edge.
- `snooze` affects only channels that are RINGING. In IDLE and SNOOZED it is ignored.
- A time match while RINGING or SNOOZED is ignored; there is no counter reload.
- Matches are not re-checked in the cycle a channel leaves RINGING. A channel returning to IDLE can only fire on a later `tick_min`.
- Comparison is full 7-bit equality. Out-of-range settings such as `amin=60` simply never match.
- Outputs:
  - `buzz` is the OR of the RINGING state bits.
  - `ring_id` is a priority encode of those bits, lowest index wins.
  - `snoozed[i]` is `state==SNOOZED`.
  - All outputs are decoded from state registers, with no input-to-output combinational path.

## Timing
- Reset: all channels go to IDLE and `cnt=0`, giving `buzz=0`, `ring_id=0`, `snoozed=0`. Reset applies on the clock edge with `rst_n=0` and overrides any in-flight ring or snooze.
- Fire latency: `buzz` rises one clock after the `tick_min` cycle in which the match is true.
- Ring duration: `buzz` falls one clock after the `RING_MINUTES`-th subsequent `tick_min`. This gives exactly `RING_MINUTES` minute boundaries of sound.
- Snooze: the channel is SNOOZED from the next edge after `snooze`. It re-rings one clock after the `SNOOZE_MIN`-th following `tick_min`.
- `snooze` and `tick_min` in the same cycle: `snooze` wins, `cnt` loads `SNOOZE_MIN`, and that tick is not counted.
- `stop` and `snooze` in the same cycle: `stop` wins and the channel goes to IDLE.
- `stop` and a fresh match in the same cycle: `stop` wins and the alarm does not fire.
- Two channels matching on the same tick both go RINGING. `ring_id` reports the lower index.

## Configuration
- `ALARM_SNOOZE_EN` defined: SNOOZED state, `snooze` input and `snoozed` output are functional, as described above.
- `ALARM_SNOOZE_EN` undefined:
  - The `snooze` input is ignored and SNOOZED is unreachable.
  - `snoozed` is tied to 0 and the counter width depends on `RING_MINUTES` only.
  - RINGING ends only by timeout, `stop`, disarm or reset.

## Test plan
- Basic fire (NUM_ALARMS=2, RING_MINUTES=1): arm=2'b01, amin[0]=30, ahrs[0]=7, time 07:30 with `tick_min` → `buzz=1`, `ring_id=0` next cycle; falls one clock after the 07:31 tick.
- Duration and no retrigger (RING_MINUTES=3): fire at 06:00 → `buzz` high through the 06:03 tick, then 0. Holding 06:00 without `tick_min` for 100 cycles after fire has no effect.
- Snooze (ALARM_SNOOZE_EN, SNOOZE_MIN=9): fire, then `snooze` pulse → `buzz=0`, `snoozed[0]=1`. After 9 ticks → `buzz=1`, `snoozed[0]=0`. A `snooze` coincident with `tick_min` still requires 9 further ticks.
- Priority: `stop` and `snooze` in the same cycle → IDLE, `snoozed=0`. Dropping `arm[0]` while SNOOZED → IDLE with no re-ring.
- Multi-channel: both channels set to 12:00 and armed → `buzz=1`, `ring_id=0`. `arm[0]` low → `ring_id=1`, `buzz` stays 1.
- Reset mid-ring: `rst_n=0` for one edge while RINGING → `buzz=0`, `ring_id=0`, `snoozed=0` after that edge; the next matching tick fires normally.
